// File: rtl/fifo_rd_pkg.sv
// Shared sizing helpers and the default stream word type for the FIFO read-side adapter.
// No logic of its own; widths are derived from the prefetch buffer depth.
// Backpressure: not applicable.
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BUF_DEPTH  = 4;

    // Pointer width for a power-of-two circular buffer.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Level counter width: must represent 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_BUF_DEPTH);
    localparam int DEF_LVL_W = lvl_width(DEF_BUF_DEPTH);

    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/stream_buf.sv
// Circular prefetch storage with pointers and an occupancy count.
// Latency: a push is visible at head/level the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module stream_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_BUF_DEPTH,
    parameter int LVL_W      = lvl_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [LVL_W-1:0]      level
);

    localparam int PTR_W = ptr_width(DEPTH);

    typedef logic [DATA_WIDTH-1:0] stream_word_t;

    stream_word_t      mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;

    // Storage is deliberately left unreset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an asynchronous FIFO (registered read data) into a valid/ready stream via a prefetch buffer.
// Latency: 2 cycles from fifo_empty falling to m_valid in an idle block; 1 word/cycle sustained.
// Backpressure: m_ready only affects registered state; reads stop once buffered + in-flight fills the buffer.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int LVL_W      = lvl_width(BUF_DEPTH)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LVL_W-1:0]      buf_level,
    output logic [31:0]           word_cnt
);

    typedef logic [DATA_WIDTH-1:0] stream_word_t;

    logic           inflight;
    logic           pop;
    logic [LVL_W:0] reserved;
    stream_word_t   head;

    // Reserve a slot for the word already requested, so the buffer can never overflow.
    assign reserved  = {1'b0, buf_level} + (LVL_W+1)'(inflight);
    assign fifo_r_en = !fifo_empty && (reserved < (LVL_W+1)'(BUF_DEPTH));

    assign m_valid = (buf_level != '0);
    assign m_data  = head;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight <= 1'b0;
            word_cnt <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (pop) begin
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end

    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .LVL_W      (LVL_W)
    ) u_buf (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .head      (head),
        .level     (buf_level)
    );

    a_no_overflow: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        inflight |-> (buf_level != LVL_W'(BUF_DEPTH))
    );

    a_stream_hold: assert property (
        @(posedge rclk) disable iff (!rrst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data))
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model with one-cycle read latency feeds the DUT,
// and a scoreboard of pushed words checks order, counts and stream stability.
module tb_fifo_rd_stream;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [LW-1:0] buf_level;
    logic [31:0]   word_cnt;

    logic          fifo_block;
    int            fifo_cnt;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int reads, pops, gaps, first_pop, last_pop, total_pushed;

    bit            have_prev, prev_valid, prev_pop;
    logic [DW-1:0] prev_data;

    logic          s_valid, s_ren;
    logic [DW-1:0] s_data;
    logic [LW-1:0] s_level;
    logic [31:0]   s_wc;

    typedef struct {
        int n;
        bit rdy;
        int lvl;
        int rd;
        int wc;
    } vec_t;

    vec_t vecs[7];

    assign fifo_empty = (fifo_cnt == 0) || fifo_block;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_level  (buf_level),
        .word_cnt   (word_cnt)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: observe at the falling edge, then apply FIFO read data just after the rising edge.
    task automatic cycle();
        bit            do_rd;
        bit            pop_now;
        logic [DW-1:0] rd_w;
        logic [DW-1:0] e;
        do_rd = 1'b0;
        rd_w  = '0;
        @(negedge rclk);
        s_valid = m_valid;
        s_ren   = fifo_r_en;
        s_data  = m_data;
        s_level = buf_level;
        s_wc    = word_cnt;
        if (rrst_n) begin
            check(m_valid == (buf_level != 0), "valid_vs_level", m_valid, buf_level != 0);
            check(buf_level <= DEPTH, "level_bound", buf_level, DEPTH);
            check(word_cnt == 32'(pops), "word_cnt_track", word_cnt, pops);
            if (have_prev && prev_valid && !prev_pop)
                check(m_valid && (m_data == prev_data), "stream_hold", m_data, prev_data);
            pop_now = m_valid && m_ready;
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_word", m_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(m_data == e, "pop_data", m_data, e);
                end
                pops++;
                if (first_pop < 0) first_pop = cyc;
                if (last_pop >= 0 && cyc != last_pop + 1) gaps++;
                last_pop = cyc;
            end
            if (fifo_r_en) begin
                reads++;
                if (fifo_q.size() == 0) begin
                    check(1'b0, "read_when_empty", fifo_r_en, 0);
                end else begin
                    do_rd = 1'b1;
                    rd_w  = fifo_q.pop_front();
                end
            end
            have_prev  = 1'b1;
            prev_valid = m_valid;
            prev_data  = m_data;
            prev_pop   = pop_now;
        end
        cyc++;
        @(posedge rclk);
        #1;
        if (do_rd) begin
            fifo_data = rd_w;
            fifo_cnt--;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_cnt++;
        total_pushed++;
    endtask

    task automatic do_reset();
        rrst_n     = 1'b0;
        m_ready    = 1'b0;
        fifo_block = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_cnt     = 0;
        fifo_data    = '0;
        have_prev    = 1'b0;
        reads        = 0;
        pops         = 0;
        gaps         = 0;
        first_pop    = -1;
        last_pop     = -1;
        total_pushed = 0;
        run(2);
        rrst_n = 1'b1;
    endtask

    initial begin
        int pc;
        rrst_n     = 1'b0;
        m_ready    = 1'b0;
        fifo_block = 1'b0;
        fifo_cnt   = 0;
        fifo_data  = '0;

        // Idle reset: values sampled while reset is held with the FIFO empty.
        do_reset();
        check(s_valid == 1'b0, "reset_valid", s_valid, 0);
        check(s_level == '0,   "reset_level", s_level, 0);
        check(s_ren == 1'b0,   "reset_r_en", s_ren, 0);
        check(s_wc == 32'd0,   "reset_word_cnt", s_wc, 0);

        // Table: preload n words, hold m_ready, let it settle, check level/reads/count.
        vecs[0] = '{0, 1'b0, 0, 0, 0};
        vecs[1] = '{1, 1'b0, 1, 1, 0};
        vecs[2] = '{3, 1'b0, 3, 3, 0};
        vecs[3] = '{4, 1'b0, 4, 4, 0};
        vecs[4] = '{7, 1'b0, 4, 4, 0};
        vecs[5] = '{2, 1'b1, 0, 2, 2};
        vecs[6] = '{6, 1'b1, 0, 6, 6};
        for (int k = 0; k < 7; k++) begin
            do_reset();
            m_ready = vecs[k].rdy;
            for (int i = 0; i < vecs[k].n; i++) push(32'(32'hD000_0000 + k * 256 + i));
            run(10);
            check(s_level == LW'(vecs[k].lvl), "vec_level", s_level, vecs[k].lvl);
            check(reads == vecs[k].rd, "vec_reads", reads, vecs[k].rd);
            check(s_wc == 32'(vecs[k].wc), "vec_word_cnt", s_wc, vecs[k].wc);
            check(s_valid == (vecs[k].lvl != 0), "vec_valid", s_valid, vecs[k].lvl != 0);
            if (!vecs[k].rdy && vecs[k].n > 0)
                check(s_data == 32'(32'hD000_0000 + k * 256), "vec_head", s_data, 32'hD000_0000 + k * 256);
        end

        // Single word: read pulse, 2-cycle latency, one handshake.
        do_reset();
        m_ready = 1'b1;
        push(32'hA5A5_0001);
        cycle();
        check(s_ren == 1'b1 && s_valid == 1'b0, "single_c0", {s_ren, s_valid}, 2'b10);
        cycle();
        check(s_ren == 1'b0 && s_valid == 1'b0, "single_c1", {s_ren, s_valid}, 2'b00);
        cycle();
        check(s_valid == 1'b1, "single_valid_c2", s_valid, 1);
        check(s_data == 32'hA5A5_0001, "single_data", s_data, 32'hA5A5_0001);
        cycle();
        check(s_valid == 1'b0 && s_wc == 32'd1, "single_done", s_wc, 1);
        check(reads == 1, "single_reads", reads, 1);

        // Streaming: 64 words back to back, no gaps after the fill.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) push(32'(i));
        pc = cyc;
        run(70);
        check(first_pop - pc == 2, "stream_first_latency", first_pop - pc, 2);
        check(gaps == 0, "stream_gaps", gaps, 0);
        check(pops == 64, "stream_pops", pops, 64);
        check(s_wc == 32'd64, "stream_word_cnt", s_wc, 64);

        // Backpressure: exactly DEPTH reads, then drain in order.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'(32'hB000_0000 + i));
        run(20);
        check(reads == DEPTH, "bp_reads", reads, DEPTH);
        check(s_level == LW'(DEPTH), "bp_level", s_level, DEPTH);
        check(s_data == 32'hB000_0000, "bp_head", s_data, 32'hB000_0000);
        m_ready = 1'b1;
        run(20);
        check(pops == 10 && reads == 10, "bp_drain", pops, 10);
        check(s_wc == 32'd10, "bp_word_cnt", s_wc, 10);
        check(exp_q.size() == 0, "bp_leftover", exp_q.size(), 0);

        // Empty race: FIFO reports empty right after the first read is issued.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(32'(32'hC000_0000 + i));
        cycle();
        fifo_block = 1'b1;
        run(6);
        check(reads == 1, "race_reads", reads, 1);
        check(pops == 1 && s_wc == 32'd1, "race_delivered", s_wc, 1);
        check(s_level == '0, "race_level", s_level, 0);
        fifo_block = 1'b0;
        run(8);
        check(s_wc == 32'd3, "race_resume", s_wc, 3);

        // Reset mid-stream with three words buffered.
        do_reset();
        m_ready = 1'b1;
        push(32'h1111_0000);
        push(32'h1111_0001);
        run(6);
        check(s_wc == 32'd2, "rst_pre_word_cnt", s_wc, 2);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'(32'h2222_0000 + i));
        run(8);
        check(s_level == LW'(3), "rst_pre_level", s_level, 3);
        rrst_n = 1'b0;
        #1;
        check(m_valid == 1'b0, "rst_async_valid", m_valid, 0);
        check(buf_level == '0, "rst_async_level", buf_level, 0);
        check(word_cnt == 32'd0, "rst_async_word_cnt", word_cnt, 0);
        do_reset();
        m_ready = 1'b1;
        push(32'hE000_0001);
        push(32'hE000_0002);
        run(8);
        check(s_wc == 32'd2 && pops == 2, "rst_resume", s_wc, 2);

        // Random traffic against the scoreboard, then a full drain.
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 2) == 0 && fifo_cnt < 16) push($urandom);
            m_ready    = ($urandom_range(0, 3) != 0);
            fifo_block = ($urandom_range(0, 7) == 0);
            cycle();
        end
        fifo_block = 1'b0;
        m_ready    = 1'b1;
        run(40);
        check(exp_q.size() == 0, "rand_leftover", exp_q.size(), 0);
        check(s_wc == 32'(total_pushed), "rand_word_cnt", s_wc, total_pushed);
        check(reads == total_pushed, "rand_reads", reads, total_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
